alu4_pipe: RTL and testbench

- Two-stage registered 4-bit ALU built from the team's 1-bit gate cells (NOT/AND/OR/NAND/NOR/XOR/XNOR).
- Sits directly downstream of the gate library as its first consumer: a bit-sliced datapath wrapped in a valid/ready pipeline.
- Stage 1 captures the operands and opcode. Stage 2 computes and holds the result and flags until the downstream stage takes them.

---
 rtl/alu4_pkg.sv | 16 +
 rtl/alu4_pipe_full_adder.sv | 75 +++++++
 rtl/alu4_pipe.sv | 147 ++++++++++++++
 tb/tb_alu4_pipe.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/alu4_pkg.sv
// Shared constants for the pipelined bit-sliced ALU: width and opcodes.
package alu4_pkg;

    localparam int unsigned ALU_WIDTH = 4;
    localparam int unsigned OP_W      = 3;

    localparam logic [OP_W-1:0] OP_AND  = 3'b000;
    localparam logic [OP_W-1:0] OP_OR   = 3'b001;
    localparam logic [OP_W-1:0] OP_NAND = 3'b010;
    localparam logic [OP_W-1:0] OP_NOR  = 3'b011;
    localparam logic [OP_W-1:0] OP_XOR  = 3'b100;
    localparam logic [OP_W-1:0] OP_XNOR = 3'b101;
    localparam logic [OP_W-1:0] OP_ADD  = 3'b110;
    localparam logic [OP_W-1:0] OP_SUB  = 3'b111;

endpackage

// File: rtl/alu4_pipe_full_adder.sv
// 1-bit gate cells and the full-adder slice composed from them.

module not_gate (
    input  logic i_a,
    output logic o_y
);
    assign o_y = ~i_a;
endmodule

module and_gate (
    input  logic i_a,
    input  logic i_b,
    output logic o_y
);
    assign o_y = i_a & i_b;
endmodule

module or_gate (
    input  logic i_a,
    input  logic i_b,
    output logic o_y
);
    assign o_y = i_a | i_b;
endmodule

module nand_gate (
    input  logic i_a,
    input  logic i_b,
    output logic o_y
);
    assign o_y = ~(i_a & i_b);
endmodule

module nor_gate (
    input  logic i_a,
    input  logic i_b,
    output logic o_y
);
    assign o_y = ~(i_a | i_b);
endmodule

module xor_gate (
    input  logic i_a,
    input  logic i_b,
    output logic o_y
);
    assign o_y = i_a ^ i_b;
endmodule

module xnor_gate (
    input  logic i_a,
    input  logic i_b,
    output logic o_y
);
    assign o_y = ~(i_a ^ i_b);
endmodule

// One ripple-carry slice: S = A^B^Cin, Cout = A&B | Cin&(A^B).
module full_adder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic S,
    output logic Cout
);
    logic w_axb;
    logic w_ab;
    logic w_cp;

    xor_gate u_x1 (.i_a(A),     .i_b(B),     .o_y(w_axb));
    xor_gate u_x2 (.i_a(w_axb), .i_b(Cin),   .o_y(S));
    and_gate u_a1 (.i_a(A),     .i_b(B),     .o_y(w_ab));
    and_gate u_a2 (.i_a(Cin),   .i_b(w_axb), .o_y(w_cp));
    or_gate  u_o1 (.i_a(w_ab),  .i_b(w_cp),  .o_y(Cout));
endmodule

// File: rtl/alu4_pipe.sv
// Two-stage valid/ready ALU: s1 captures operands, s2 computes and holds
// the result and flags until the consumer takes them. WIDTH must be >= 2.
module alu4_pipe
    import alu4_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [OP_W-1:0]  op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] C,
    output logic             carry,
    output logic             zero,
    output logic             ovf
);

    logic             r_s1_valid;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [OP_W-1:0]  r_op;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_c;
    logic             r_carry;
    logic             r_zero;
    logic             r_ovf;

    logic             w_s2_free;
    logic             w_s1_load;
    logic             w_s2_load;

    logic             w_is_sub;
    logic             w_is_arith;
    logic [WIDTH-1:0] w_b_n;
    logic [WIDTH-1:0] w_b_add;
    logic [WIDTH:0]   w_cy;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_and;
    logic [WIDTH-1:0] w_or;
    logic [WIDTH-1:0] w_nand;
    logic [WIDTH-1:0] w_nor;
    logic [WIDTH-1:0] w_xor;
    logic [WIDTH-1:0] w_xnor;
    logic [WIDTH-1:0] w_result;
    logic             w_zero;
    logic             w_carry;
    logic             w_ovf;

    // Handshake: s2 can take a new item when empty or being drained.
    assign w_s2_free = !r_out_valid || out_ready;
    assign in_ready  = !r_s1_valid || w_s2_free;
    assign w_s1_load = in_valid && in_ready;
    assign w_s2_load = r_s1_valid && w_s2_free;

    // Stage 1: capture operands; payload holds whenever no new item loads.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_a        <= '0;
            r_b        <= '0;
            r_op       <= '0;
        end else if (w_s1_load) begin
            r_s1_valid <= 1'b1;
            r_a        <= A;
            r_b        <= B;
            r_op       <= op;
        end else if (w_s2_load) begin
            r_s1_valid <= 1'b0;
        end
    end

    assign w_is_sub   = (r_op == OP_SUB);
    assign w_is_arith = (r_op == OP_ADD) || w_is_sub;
    assign w_b_add    = w_is_sub ? w_b_n : r_b;
    assign w_cy[0]    = w_is_sub;

    // Bit-sliced datapath: one gate-cell set and adder slice per bit.
    for (genvar g = 0; g < WIDTH; g++) begin : g_slice
        not_gate   u_not  (.i_a(r_b[g]),                 .o_y(w_b_n[g]));
        and_gate   u_and  (.i_a(r_a[g]), .i_b(r_b[g]),   .o_y(w_and[g]));
        or_gate    u_or   (.i_a(r_a[g]), .i_b(r_b[g]),   .o_y(w_or[g]));
        nand_gate  u_nand (.i_a(r_a[g]), .i_b(r_b[g]),   .o_y(w_nand[g]));
        nor_gate   u_nor  (.i_a(r_a[g]), .i_b(r_b[g]),   .o_y(w_nor[g]));
        xor_gate   u_xor  (.i_a(r_a[g]), .i_b(r_b[g]),   .o_y(w_xor[g]));
        xnor_gate  u_xnor (.i_a(r_a[g]), .i_b(r_b[g]),   .o_y(w_xnor[g]));
        full_adder u_fa (
            .A    (r_a[g]),
            .B    (w_b_add[g]),
            .Cin  (w_cy[g]),
            .S    (w_sum[g]),
            .Cout (w_cy[g+1])
        );
    end

    // Result select by registered opcode.
    always_comb begin
        w_result = '0;
        case (r_op)
            OP_AND:  w_result = w_and;
            OP_OR:   w_result = w_or;
            OP_NAND: w_result = w_nand;
            OP_NOR:  w_result = w_nor;
            OP_XOR:  w_result = w_xor;
            OP_XNOR: w_result = w_xnor;
            OP_ADD:  w_result = w_sum;
            OP_SUB:  w_result = w_sum;
            default: w_result = '0;
        endcase
    end

    // Flags: adder flags only meaningful for ADD/SUB; zero for every op.
    assign w_zero  = ~(|w_result);
    assign w_carry = w_is_arith & w_cy[WIDTH];
    assign w_ovf   = w_is_arith & (w_cy[WIDTH] ^ w_cy[WIDTH-1]);

    // Stage 2: load a computed result, or retire the held one when taken.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_c         <= '0;
            r_carry     <= 1'b0;
            r_zero      <= 1'b1;
            r_ovf       <= 1'b0;
        end else if (w_s2_load) begin
            r_out_valid <= 1'b1;
            r_c         <= w_result;
            r_carry     <= w_carry;
            r_zero      <= w_zero;
            r_ovf       <= w_ovf;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign C         = r_c;
    assign carry     = r_carry;
    assign zero      = r_zero;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_alu4_pipe.sv
// Directed bench for alu4_pipe: reset, arithmetic/logic vectors,
// backpressure streaming and mid-flight reset.
module tb_alu4_pipe;
    import alu4_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] A;
    logic [3:0] B;
    logic [2:0] op;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] C;
    logic       carry;
    logic       zero;
    logic       ovf;

    int vectors;
    int miscompares;

    alu4_pipe #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .C         (C),
        .carry     (carry),
        .zero      (zero),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one item, let it travel two edges, then check the result.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [3:0] a,
                          input logic [3:0] b, input logic [3:0] ec, input logic ecy,
                          input logic ez, input logic eo);
        in_valid = 1'b1;
        op = o;
        A = a;
        B = b;
        #1;
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk({tag, "_lat1"}, 32'(out_valid), 32'd0);
        tick();
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_C"}, 32'(C), 32'(ec));
        chk({tag, "_carry"}, 32'(carry), 32'(ecy));
        chk({tag, "_zero"}, 32'(zero), 32'(ez));
        chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
        tick();
    endtask

    initial begin
        int idx;
        int rcv;
        int rcv_cyc [5];
        int exp_cyc [5];

        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        in_valid    = 1'b1;
        out_ready   = 1'b1;
        A           = 4'd7;
        B           = 4'd1;
        op          = OP_ADD;

        // Reset held for 3 edges while upstream offers data.
        repeat (3) tick();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_C", 32'(C), 32'd0);
        chk("rst_zero", 32'(zero), 32'd1);
        chk("rst_carry", 32'(carry), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        tick();

        // Arithmetic and logic vectors, out_ready held high.
        run_op("add_7_1",  OP_ADD,  4'b0111, 4'b0001, 4'b1000, 1'b0, 1'b0, 1'b1);
        run_op("add_f_1",  OP_ADD,  4'b1111, 4'b0001, 4'b0000, 1'b1, 1'b1, 1'b0);
        run_op("sub_3_5",  OP_SUB,  4'b0011, 4'b0101, 4'b1110, 1'b0, 1'b0, 1'b0);
        run_op("sub_8_1",  OP_SUB,  4'b1000, 4'b0001, 4'b0111, 1'b1, 1'b0, 1'b1);
        run_op("xor",      OP_XOR,  4'b1010, 4'b0110, 4'b1100, 1'b0, 1'b0, 1'b0);
        run_op("xnor",     OP_XNOR, 4'b1010, 4'b0110, 4'b0011, 1'b0, 1'b0, 1'b0);
        run_op("nor",      OP_NOR,  4'b0000, 4'b0000, 4'b1111, 1'b0, 1'b0, 1'b0);
        run_op("nand",     OP_NAND, 4'b1111, 4'b1111, 4'b0000, 1'b0, 1'b1, 1'b0);
        run_op("and",      OP_AND,  4'b1100, 4'b1010, 4'b1000, 1'b0, 1'b0, 1'b0);
        run_op("or",       OP_OR,   4'b0101, 4'b1010, 4'b1111, 1'b0, 1'b1 ^ 1'b1, 1'b0);

        // Backpressure: 5 ADDs k+1, out_ready low during cycles 3..6.
        exp_cyc = '{2, 7, 8, 9, 10};
        idx = 0;
        rcv = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            in_valid  = (idx < 5);
            op        = OP_ADD;
            A         = 4'(idx);
            B         = 4'd1;
            out_ready = !(cyc >= 3 && cyc <= 6);
            #1;
            if (cyc <= 8)
                chk($sformatf("bp_in_ready_c%0d", cyc), 32'(in_ready),
                    32'(!(cyc >= 3 && cyc <= 6)));
            if (out_valid) begin
                chk($sformatf("bp_C_c%0d", cyc), 32'(C), 32'(rcv + 1));
                if (out_ready) begin
                    if (rcv < 5) rcv_cyc[rcv] = cyc;
                    rcv++;
                end
            end
            if (in_valid && in_ready) idx++;
            tick();
        end
        chk("bp_count", 32'(rcv), 32'd5);
        for (int k = 0; k < 5; k++)
            chk($sformatf("bp_cycle_%0d", k), 32'(rcv_cyc[k]), 32'(exp_cyc[k]));

        // Mid-flight reset with two items in the pipe.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        op        = OP_ADD;
        A         = 4'd2;
        B         = 4'd3;
        tick();
        A = 4'd4;
        tick();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        chk("mrst_valid", 32'(out_valid), 32'd0);
        chk("mrst_C", 32'(C), 32'd0);
        chk("mrst_zero", 32'(zero), 32'd1);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("mrst_drain_%0d", k), 32'(out_valid), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
